boot_loader_ctrl: RTL

Hardware boot loader sequencer for the Amber system on Marsohod2. Parses framed write records from the UART receive byte stream, writes 32-bit words into the boot memory write port, and answers each frame with an ACK/NAK byte on the UART transmit path. It holds the CPU in reset from power-up until a GO frame is accepted. This replaces file-based boot memory preloading on hardware.

---
 rtl/boot_loader_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/boot_loader_ctrl.sv
`default_nettype none
// boot_loader_ctrl: parses UART write/GO frames into boot memory writes and holds the CPU in reset until GO.
// Revision 1.0
module boot_loader_ctrl #(
  parameter int AW      = 11,
  parameter int TIMEOUT = 80000
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [7:0]    i_rx_data,
  input  logic          i_rx_valid,
  output logic [7:0]    o_tx_data,
  output logic          o_tx_valid,
  input  logic          i_tx_ready,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [31:0]   o_mem_wdata,
  output logic          o_cpu_rst,
  output logic [15:0]   o_word_count,
  output logic          o_overrun
);
  localparam logic [7:0] SYNC      = 8'h55;
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_GO    = 8'h02;
  localparam logic [7:0] ACK       = 8'h06;
  localparam logic [7:0] NAK       = 8'h15;
  localparam int         TW        = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DATA, S_CHK, S_EXEC, S_RESP, S_RUN
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    byte_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    cmd, chk_acc;
  logic [31:0]   addr, data;
  logic          ack, go_accepted;
  logic          in_frame, timed_out, chk_match, addr_ok, write_ok, go_ok, handshake;

  always_comb begin
    in_frame  = (state == S_CMD) || (state == S_ADDR) || (state == S_DATA) || (state == S_CHK);
    timed_out = in_frame && !i_rx_valid && (tmo_cnt == TW'(TIMEOUT - 1));
    chk_match = (i_rx_data == chk_acc);
    addr_ok   = ((addr >> (AW + 2)) == 32'd0) && (addr[1:0] == 2'b00);
    write_ok  = chk_match && (cmd == CMD_WRITE) && addr_ok;
    go_ok     = chk_match && (cmd == CMD_GO);
    handshake = o_tx_valid && i_tx_ready;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_rx_valid && i_rx_data == SYNC) state_nxt = S_CMD;
      S_CMD:   if (i_rx_valid) state_nxt = S_ADDR;
      S_ADDR:  if (i_rx_valid && byte_cnt == 2'd3) state_nxt = S_DATA;
      S_DATA:  if (i_rx_valid && byte_cnt == 2'd3) state_nxt = S_CHK;
      S_CHK:   if (i_rx_valid) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_RESP;
      S_RESP:  if (handshake) state_nxt = go_accepted ? S_RUN : S_IDLE;
      S_RUN:   state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
    if (timed_out) state_nxt = S_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= S_IDLE;
      byte_cnt     <= '0;
      tmo_cnt      <= '0;
      cmd          <= '0;
      chk_acc      <= '0;
      addr         <= '0;
      data         <= '0;
      ack          <= 1'b0;
      go_accepted  <= 1'b0;
      o_tx_data    <= '0;
      o_tx_valid   <= 1'b0;
      o_mem_we     <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_wdata  <= '0;
      o_cpu_rst    <= 1'b1;
      o_word_count <= '0;
      o_overrun    <= 1'b0;
    end else begin
      state    <= state_nxt;
      o_mem_we <= 1'b0;

      // Idle cycles inside a frame count toward the timeout; any byte restarts it.
      if (in_frame && !i_rx_valid) tmo_cnt <= tmo_cnt + 1'b1;
      else                         tmo_cnt <= '0;

      if (state == S_IDLE) byte_cnt <= '0;

      if (i_rx_valid) begin
        case (state)
          S_CMD: begin
            cmd     <= i_rx_data;
            chk_acc <= i_rx_data;
          end
          S_ADDR: begin
            addr     <= {addr[23:0], i_rx_data};
            chk_acc  <= chk_acc ^ i_rx_data;
            byte_cnt <= byte_cnt + 2'd1;
          end
          S_DATA: begin
            data     <= {data[23:0], i_rx_data};
            chk_acc  <= chk_acc ^ i_rx_data;
            byte_cnt <= byte_cnt + 2'd1;
          end
          S_CHK: begin
            // Decision is taken on the CHK byte so the write strobe lands in EXEC.
            o_mem_we    <= write_ok;
            ack         <= write_ok || go_ok;
            go_accepted <= go_ok;
            o_mem_addr  <= addr[AW+1:2];
            o_mem_wdata <= data;
          end
          S_EXEC, S_RESP: o_overrun <= 1'b1;
          default: ;
        endcase
      end

      if (state == S_EXEC) begin
        o_tx_valid <= 1'b1;
        o_tx_data  <= ack ? ACK : NAK;
        if (o_mem_we && o_word_count != 16'hFFFF) o_word_count <= o_word_count + 16'd1;
      end

      if (state == S_RESP && handshake) begin
        o_tx_valid <= 1'b0;
        if (go_accepted) o_cpu_rst <= 1'b0;
      end
    end
  end
endmodule
`default_nettype wire
